// File: rtl/jtag_host_pkg.sv
// Shared types and TMS pattern constants for the JTAG host driver.
// Patterns are stored LSB first: bit i is the TMS value of the i-th TCK.
package jtag_host_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'd0,
        OP_SHIFT_IR  = 2'd1,
        OP_SHIFT_DR  = 2'd2,
        OP_RUN_IDLE  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RSP
    } state_e;

    localparam logic [7:0] RESET_TMS  = 8'b0011_1111;
    localparam int         RESET_LEN  = 7;
    localparam logic [7:0] IR_PRE_TMS = 8'b0000_0011;
    localparam int         IR_PRE_LEN = 4;
    localparam logic [7:0] DR_PRE_TMS = 8'b0000_0001;
    localparam int         DR_PRE_LEN = 3;
    localparam logic [7:0] POST_TMS   = 8'b0000_0001;
    localparam int         POST_LEN   = 2;

    function automatic logic pre_tms(input op_e op, input logic [2:0] idx);
        case (op)
            OP_TAP_RESET: return RESET_TMS[idx];
            OP_SHIFT_IR:  return IR_PRE_TMS[idx];
            OP_SHIFT_DR:  return DR_PRE_TMS[idx];
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] pre_last(input op_e op);
        case (op)
            OP_TAP_RESET: return 3'(RESET_LEN - 1);
            OP_SHIFT_IR:  return 3'(IR_PRE_LEN - 1);
            OP_SHIFT_DR:  return 3'(DR_PRE_LEN - 1);
            default:      return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/jtag_host_driver_tck_gen.sv
// TCK divider: low phase then high phase of TCK_DIV clks each, with strobes
// flagging the clk edge that drives tck high (rise_en) or low (fall_en).
module jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic fall_en,
    output logic rise_en
);
    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          at_end;

    assign at_end  = (cnt == CW'(TCK_DIV - 1));
    assign rise_en = en & at_end & ~tck;
    assign fall_en = en & at_end & tck;

    // Disabling clears the phase so every command starts with a full low phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (at_end) begin
            cnt <= '0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/jtag_host_driver.sv
// JTAG initiator: turns queued TAP commands into TCK/TMS/TDI waveforms and
// returns the captured TDO bits, one response per command.
module jtag_host_driver
    import jtag_host_pkg::*;
#(
    parameter  int TCK_DIV = 2,
    parameter  int MAX_LEN = 64,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LW-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    state_e             state;
    op_e                op_q;
    logic [2:0]         idx;
    logic [LW-1:0]      bit_cnt;
    logic [LW-1:0]      len_q;
    logic [MAX_LEN-1:0] tx;
    logic [MAX_LEN-1:0] rx;
    logic               is_idle;
    logic               tck_en;
    logic               fall_en;
    logic               rise_en;
    logic [LW-1:0]      len_clamped;

    assign tck_en   = (state == ST_PRE) || (state == ST_SHIFT) || (state == ST_POST);
    assign rsp_data = rx;
    assign len_clamped = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;

    jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (tck_en),
        .tck     (tck),
        .fall_en (fall_en),
        .rise_en (rise_en)
    );

    // NOTE: all FSM state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_TAP_RESET;
            idx       <= '0;
            bit_cnt   <= '0;
            len_q     <= '0;
            tx        <= '0;
            rx        <= '0;
            is_idle   <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    op_q      <= op_e'(cmd_op);
                    idx       <= '0;
                    bit_cnt   <= '0;
                    rx        <= '0;
                    tdi       <= 1'b0;
                    cmd_ready <= 1'b0;
                    is_idle   <= (op_e'(cmd_op) == OP_RUN_IDLE);
                    tx        <= (op_e'(cmd_op) == OP_RUN_IDLE) ? '0 : cmd_data;
                    case (op_e'(cmd_op))
                        OP_TAP_RESET: begin
                            len_q <= '0;
                            state <= ST_PRE;
                            tms   <= pre_tms(OP_TAP_RESET, 3'd0);
                        end
                        OP_RUN_IDLE: begin
                            len_q <= cmd_len;
                            tms   <= 1'b0;
                            if (cmd_len == '0) begin
                                state     <= ST_RSP;
                                rsp_valid <= 1'b1;
                            end else begin
                                state <= ST_SHIFT;
                            end
                        end
                        default: begin
                            len_q <= len_clamped;
                            if (len_clamped == '0) begin
                                state     <= ST_RSP;
                                rsp_valid <= 1'b1;
                            end else begin
                                state <= ST_PRE;
                                tms   <= pre_tms(op_e'(cmd_op), 3'd0);
                            end
                        end
                    endcase
                end

                ST_PRE: if (fall_en) begin
                    if (idx == pre_last(op_q)) begin
                        idx <= '0;
                        if (op_q == OP_TAP_RESET) begin
                            state     <= ST_RSP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                            tms   <= (len_q == LW'(1));
                            tdi   <= tx[0];
                        end
                    end else begin
                        idx <= idx + 3'd1;
                        tms <= pre_tms(op_q, idx + 3'd1);
                    end
                end

                ST_SHIFT: begin
                    if (rise_en && !is_idle)
                        rx <= rx | ({{(MAX_LEN-1){1'b0}}, tdo} << bit_cnt);
                    if (fall_en) begin
                        if (bit_cnt == len_q - LW'(1)) begin
                            tdi <= 1'b0;
                            if (is_idle) begin
                                state     <= ST_RSP;
                                rsp_valid <= 1'b1;
                            end else begin
                                state <= ST_POST;
                                tms   <= POST_TMS[0];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + LW'(1);
                            tx      <= tx >> 1;
                            tdi     <= tx[1];
                            tms     <= !is_idle && (bit_cnt + LW'(2) == len_q);
                        end
                    end
                end

                ST_POST: if (fall_en) begin
                    if (idx == 3'(POST_LEN - 1)) begin
                        idx       <= '0;
                        state     <= ST_RSP;
                        rsp_valid <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                        tms <= POST_TMS[idx + 3'd1];
                    end
                end

                ST_RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver against a behavioural 1149.1 TAP
// model holding IDCODE 0xDEADBEEF (IR 5'b00001) and BYPASS for other IRs.
module tb_jtag_host_driver;

    localparam int TCK_DIV = 2;
    localparam int MAX_LEN = 64;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'd0;
    logic [LW-1:0]      cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [MAX_LEN-1:0] rsp_data;
    logic               tck;
    logic               tms;
    logic               tdi;
    logic               tdo;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jtag_host_driver #(.TCK_DIV(TCK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    // ---------------- behavioural TAP model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    localparam logic [4:0] IR_IDCODE = 5'b00001;

    tap_e        ts    = TLR;
    logic [4:0]  ir    = IR_IDCODE;
    logic [4:0]  ir_sr = '0;
    logic [31:0] dr    = '0;
    logic        byp   = 1'b0;
    logic        tdo_m = 1'b0;

    assign tdo = tdo_m;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:     return m ? TLR    : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PAU_DR;
            PAU_DR:  return m ? EX2_DR : PAU_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PAU_IR;
            PAU_IR:  return m ? EX2_IR : PAU_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (ts)
            TLR:    ir <= IR_IDCODE;
            CAP_DR: if (ir == IR_IDCODE) dr <= 32'hDEADBEEF; else byp <= 1'b0;
            SH_DR:  if (ir == IR_IDCODE) dr <= {tdi, dr[31:1]}; else byp <= tdi;
            CAP_IR: ir_sr <= 5'b00001;
            SH_IR:  ir_sr <= {tdi, ir_sr[4:1]};
            UPD_IR: ir <= ir_sr;
            default: ;
        endcase
        ts <= tap_next(ts, tms);
    end

    always @(negedge tck) begin
        if (ts == SH_DR)      tdo_m <= (ir == IR_IDCODE) ? dr[0] : byp;
        else if (ts == SH_IR) tdo_m <= ir_sr[0];
        else                  tdo_m <= 1'b0;
    end

    // ---------------- TCK monitor ----------------
    int          tck_cnt   = 0;
    logic [15:0] tms_trace = '0;

    always @(posedge tck) begin
        if (tck_cnt < 16) tms_trace[tck_cnt] = tms;
        tck_cnt = tck_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one command; returns cycles from acceptance edge to rsp_valid.
    task automatic send(input logic [1:0] op, input int len, input logic [63:0] data,
                        output int lat);
        int n;
        cmd_op    = op;
        cmd_len   = LW'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
        tck_cnt   = 0;
        tms_trace = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 1000) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        int          len;
        logic [63:0] data;
        logic [63:0] exp_rsp;
        int          exp_tck;
        logic        chk_tms;
        logic [15:0] exp_tms;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        logic seen;

        // op, len, data, expected rsp_data, expected TCKs, check tms?, tms trace (LSB first)
        vecs[0]  = '{2'd0,   0, 64'h0,                   64'h0,                   7,  1'b1, 16'h003F};
        vecs[1]  = '{2'd1,   5, 64'h01,                  64'h01,                  11, 1'b1, 16'h0303};
        vecs[2]  = '{2'd2,  32, 64'h0,                   64'hDEADBEEF,            37, 1'b0, 16'h0000};
        vecs[3]  = '{2'd3,   3, 64'hFFFF,                64'h0,                   3,  1'b1, 16'h0000};
        vecs[4]  = '{2'd3,   0, 64'h0,                   64'h0,                   0,  1'b1, 16'h0000};
        vecs[5]  = '{2'd2,   0, 64'hFF,                  64'h0,                   0,  1'b1, 16'h0000};
        vecs[6]  = '{2'd2,  32, 64'h12345678,            64'hDEADBEEF,            37, 1'b0, 16'h0000};
        vecs[7]  = '{2'd1,   5, 64'h1F,                  64'h01,                  11, 1'b1, 16'h0303};
        vecs[8]  = '{2'd2,   8, 64'hA5,                  64'h4A,                  13, 1'b1, 16'h0C01};
        vecs[9]  = '{2'd2, 100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 69, 1'b0, 16'h0000};
        vecs[10] = '{2'd2,   1, 64'h1,                   64'h0,                   6,  1'b1, 16'h0019};
        vecs[11] = '{2'd2,  16, 64'h8001,                64'h0002,                21, 1'b0, 16'h0000};
        vecs[12] = '{2'd0,   0, 64'h0,                   64'h0,                   7,  1'b1, 16'h003F};
        vecs[13] = '{2'd2,  32, 64'h0,                   64'hDEADBEEF,            37, 1'b0, 16'h0000};

        // Reset values while rst is held.
        #23;
        check("reset_ctrl {tck,tms,tdi,cmd_ready,rsp_valid}",
              64'({tck, tms, tdi, cmd_ready, rsp_valid}), 64'b01010);
        check("reset_rsp_data", rsp_data, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            send(vecs[i].op, vecs[i].len, vecs[i].data, lat);
            check($sformatf("vec%0d rsp_data", i), rsp_data, vecs[i].exp_rsp);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(2 * vecs[i].exp_tck * TCK_DIV));
            check($sformatf("vec%0d tck_count", i), 64'(tck_cnt), 64'(vecs[i].exp_tck));
            if (vecs[i].chk_tms)
                check($sformatf("vec%0d tms_trace", i), 64'(tms_trace), 64'(vecs[i].exp_tms));
            take_rsp();
        end

        // Response back-pressure: outputs hold while rsp_ready stays low.
        send(2'd2, 32, 64'h0, lat);
        check("hold latency", 64'(lat), 64'd148);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d {rsp_valid,cmd_ready,tck}", c),
                  64'({rsp_valid, cmd_ready, tck}), 64'b100);
            check($sformatf("hold%0d rsp_data", c), rsp_data, 64'hDEADBEEF);
        end

        // Back-to-back: command waiting during the handshake is taken one edge later.
        cmd_op    = 2'd0;
        cmd_len   = '0;
        cmd_data  = '0;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        tck_cnt   = 0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("handshake {cmd_ready,rsp_valid}", 64'({cmd_ready, rsp_valid}), 64'b10);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("b2b accepted cmd_ready", 64'(cmd_ready), 64'd0);
        lat = 0;
        while (!rsp_valid && lat < 1000) begin
            @(posedge clk); #1; lat++;
        end
        check("b2b latency", 64'(lat), 64'd28);
        check("b2b tck_count", 64'(tck_cnt), 64'd7);
        take_rsp();

        // Reset in the middle of a 32-bit shift.
        cmd_op    = 2'd2;
        cmd_len   = LW'(32);
        cmd_data  = '0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (60) begin @(posedge clk); #1; end
        n = 0;
        while (!tck && n < 10) begin
            @(posedge clk); #1; n++;
        end
        check("tck high before mid reset", 64'(tck), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_reset {tck,tms,tdi,cmd_ready,rsp_valid}",
              64'({tck, tms, tdi, cmd_ready, rsp_valid}), 64'b01010);
        check("mid_reset rsp_data", rsp_data, 64'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        tck_cnt = 0;
        seen = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("no response after reset", 64'(seen), 64'd0);
        check("no tck after reset", 64'(tck_cnt), 64'd0);

        send(2'd0, 0, 64'h0, lat);
        check("recover tap_reset latency", 64'(lat), 64'd28);
        take_rsp();
        send(2'd2, 32, 64'h0, lat);
        check("recover idcode", rsp_data, 64'hDEADBEEF);
        check("recover idcode latency", 64'(lat), 64'd148);
        take_rsp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_host_driver.md
# jtag_host_driver

Synthesizable JTAG initiator that turns queued scan commands into TCK/TMS/TDI waveforms and captures TDO. It is the host end of the debug-transport pins (tck, tms, tdi, tdo) that the FPGA top exposes, so a simulation or self-test harness can drive the Debug Transport Module through its TAP without an external probe. Commands and responses use valid/ready handshakes. The block runs entirely in the system clock domain and generates TCK by clock division.

## Interface
- TCK_DIV, 2: clk cycles per TCK half-period; must be ≥1.
- MAX_LEN, 64: maximum shift length in bits.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  0 = TAP_RESET, 1 = SHIFT_IR, 2 = SHIFT_DR, 3 = RUN_IDLE.
- cmd_len  in  $clog2(MAX_LEN+1)  shift bit count, or idle TCK count.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  MAX_LEN  captured TDO, bit i = i-th shifted bit; bits ≥ len are zero.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target.

## Operation
- Reset values:
  - Outputs: tck=0, tms=1, tdi=0, cmd_ready=1, rsp_valid=0, rsp_data=0.
  - State: FSM in IDLE, all counters zero.
- Commands other than TAP_RESET assume the target TAP is in Run-Test/Idle, and every command leaves it there.
- States:
  - IDLE: cmd_ready=1 here only.
  - PRE: emits the TMS preamble.
  - SHIFT: emits the data bits.
  - POST: emits the TMS postamble.
  - RSP: rsp_valid=1; returns to IDLE on rsp_ready.
- TMS sequence per op (one value per TCK):
  - TAP_RESET: 1,1,1,1,1,1,0 (7 TCKs).
  - SHIFT_DR: PRE 1,0,0; SHIFT len TCKs with tms=0 except the last, which has tms=1; POST 1,0.
  - SHIFT_IR: PRE 1,1,0,0; SHIFT and POST as for SHIFT_DR.
  - RUN_IDLE: len TCKs with tms=0.
- tdi carries cmd_data[k] during the k-th SHIFT TCK; tdi=0 during all other TCKs.
- TDO is captured into rsp_data[k] during the k-th SHIFT TCK.
- Every command produces exactly one response. rsp_data is 0 for TAP_RESET and RUN_IDLE.
- Length rules:
  - A shift with len=0 emits no TCK and goes straight to RSP with rsp_data=0.
  - len > MAX_LEN is clamped to MAX_LEN.
  - RUN_IDLE with len=0 emits no TCK.
- Reset mid-command: outputs go to their reset values immediately and no response is produced. The target TAP state is then undefined, and software must issue TAP_RESET.

## Timing
- A command is accepted on the clk edge where cmd_valid & cmd_ready.
- Each TCK period is a low phase of TCK_DIV clks followed by a high phase of TCK_DIV clks.
- tms/tdi update on the edge that drives tck low (the start of the low phase). The first low phase starts on the edge after acceptance.
- tdo is sampled on the clk edge that drives tck 0→1.
- After the last high phase, tck returns to 0 and rsp_valid rises on that same edge.
- Latency: for T emitted TCKs, rsp_valid=1 exactly 2·T·TCK_DIV cycles after acceptance. Example: SHIFT_DR len 8 gives T=13.
- rsp_valid and rsp_data hold stable until rsp_ready. cmd_ready stays 0 until the edge after the response handshake.
- tck is never high outside PRE, SHIFT and POST.

## Structure
- Shared package jtag_host_pkg holds:
  - the op encoding enum;
  - the FSM state enum;
  - preamble/postamble TMS constants and their lengths.
- Sub-module jtag_tck_gen is a divider counter producing a tck level plus one-cycle fall_en/rise_en strobes, enabled only when the FSM requests a TCK.
- The top FSM holds the bit counter, the preamble index, the TX shift register and the RX shift register.

## Test plan
All scenarios use TCK_DIV=2, MAX_LEN=64, and a behavioural IEEE 1149.1 TAP model with IDCODE 0xDEADBEEF.
- TAP_RESET then SHIFT_IR len 5 data 0x01 → tms trace matches the listed sequence; rsp_data 0x01 (IR capture pattern xxx01 masked to 5 bits).
- SHIFT_DR len 32 data 0 → rsp_data=0xDEADBEEF; rsp_valid exactly 2·37·2=148 cycles after acceptance.
- Model in BYPASS, SHIFT_DR len 8 data 0xA5 → rsp_data=0x4A (1-bit delay, captured 0 first); bits 63:8 zero.
- SHIFT_DR len 0 → no tck edge, rsp_valid on the next cycle, rsp_data=0; len 100 → exactly 64 shift TCKs.
- Hold rsp_ready=0 for 20 cycles → rsp_valid/rsp_data stable, cmd_ready=0, tck static; on release a back-to-back command is accepted the cycle after the handshake.
- Assert rst midway through a 32-bit shift → outputs reach reset values on the same edge and no rsp_valid follows; the next TAP_RESET + IDCODE read returns 0xDEADBEEF.
